// File: rtl/seq_mult_unit.sv
// Multi-cycle shift-add multiplier with unsigned/signed modes and a full 2*WIDTH-bit product.
// Optional macro SEQ_MULT_EARLY_TERM_EN ends RUN once the remaining multiplier bits are all zero.
module seq_mult_unit #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_prod_hi;
  logic [WIDTH-1:0]   r_prod_lo;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_mplier_shr;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_result;
  logic               w_last;

  // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude.
  assign w_a_mag      = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign w_b_mag      = (signed_mode && b[WIDTH-1]) ? -b : b;
  assign w_mplier_shr = r_mplier >> 1;
  assign w_acc_next   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_result     = r_neg ? -w_acc_next : w_acc_next;

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (w_mplier_shr == '0);
`else
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_state  <= StRun;
            r_busy   <= 1'b1;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_cnt    <= '0;
            r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end else begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        StRun: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_shr;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state   <= StDone;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_prod_hi <= w_result[2*WIDTH-1:WIDTH];
            r_prod_lo <= w_result[WIDTH-1:0];
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign product_hi = r_prod_hi;
  assign product_lo = r_prod_lo;

endmodule
